// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: angle scale (131 LSB/deg), gain, atan table, states.
// Imported by the rotation and vectoring CORDIC blocks.
package cordic_pkg;

    localparam int ANG_45  = 5895;
    localparam int ANG_90  = 11790;
    localparam int ANG_180 = 23580;
    localparam int K_Q14   = 9949;
    localparam int K_SHIFT = 14;

    localparam logic signed [23:0] ATAN_TBL [0:15] = '{
        24'sd5895, 24'sd3480, 24'sd1839, 24'sd933,
        24'sd468,  24'sd234,  24'sd117,  24'sd59,
        24'sd29,   24'sd15,   24'sd7,    24'sd4,
        24'sd2,    24'sd1,    24'sd0,    24'sd0
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCALE  = 2'd1,
        ST_ROTATE = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/cordic_atan_lut.sv
// atan(2^-idx) in 131 LSB/deg units.
// Ports: idx (4-bit table index) -> atan (24-bit signed angle).
module cordic_atan_lut
    import cordic_pkg::*;
(
    input  logic [3:0]  idx,
    output logic [23:0] atan
);

    assign atan = ATAN_TBL[idx];

endmodule

// File: rtl/cordic_rotate.sv
// Iterative rotation-mode CORDIC: (angle, magnitude) -> (x, y).
// Ports: clk, rst_n, crd_start/angle/magnitude in; crd_busy/done/x/y out.
module cordic_rotate
    import cordic_pkg::*;
#(
    parameter int ITERATIONS = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        crd_start,
    input  logic [23:0] crd_angle,
    input  logic [23:0] crd_magnitude,
    output logic        crd_busy,
    output logic        crd_done,
    output logic [23:0] crd_x,
    output logic [23:0] crd_y
);

    localparam logic signed [23:0] A90  = 24'(ANG_90);
    localparam logic signed [23:0] A180 = 24'(ANG_180);
    localparam logic signed [37:0] KG   = 38'(K_Q14);
    localparam logic [4:0]         ILAST = 5'(ITERATIONS - 1);

    state_t state, state_nx;

    logic signed [23:0] ang_r, mag_r;
    logic signed [23:0] x_r, y_r, z_r;
    logic [4:0]         i_r;

    logic signed [37:0] prod;
    logic signed [23:0] p, ang_c, x0, z0;
    logic signed [23:0] xs, ys, atan_i;
    logic [23:0]        atan_raw;
    logic               unused_ok;

    cordic_atan_lut u_lut (
        .idx  (i_r[3:0]),
        .atan (atan_raw)
    );

    assign atan_i = atan_raw;

    // Pre-divide by the CORDIC gain; the >>>14 is the top 24 product bits.
    assign prod      = 38'(mag_r) * KG;
    assign p         = prod[37:K_SHIFT];
    assign unused_ok = ^prod[K_SHIFT-1:0];

    assign xs = x_r >>> i_r;
    assign ys = y_r >>> i_r;

    // Fold angles beyond +/-90 deg into range by starting from -p.
    always_comb begin
        ang_c = ang_r;
        if (ang_r > A180)
            ang_c = A180;
        else if (ang_r < -A180)
            ang_c = -A180;
        x0 = p;
        z0 = ang_c;
        unique case (1'b1)
            (ang_c > A90): begin
                z0 = ang_c - A180;
                x0 = -p;
            end
            (ang_c < -A90): begin
                z0 = ang_c + A180;
                x0 = -p;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (crd_start && crd_magnitude != 24'd0)
                    state_nx = ST_SCALE;
            end
            ST_SCALE:  state_nx = ST_ROTATE;
            ST_ROTATE: begin
                if (i_r == ILAST)
                    state_nx = ST_FINISH;
            end
            ST_FINISH: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ang_r    <= '0;
            mag_r    <= '0;
            x_r      <= '0;
            y_r      <= '0;
            z_r      <= '0;
            i_r      <= '0;
            crd_busy <= 1'b0;
            crd_done <= 1'b0;
            crd_x    <= '0;
            crd_y    <= '0;
        end else begin
            crd_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (crd_start) begin
                        if (crd_magnitude == 24'd0) begin
                            crd_x    <= '0;
                            crd_y    <= '0;
                            crd_done <= 1'b1;
                        end else begin
                            ang_r    <= crd_angle;
                            mag_r    <= crd_magnitude;
                            crd_busy <= 1'b1;
                        end
                    end
                end
                ST_SCALE: begin
                    x_r <= x0;
                    y_r <= '0;
                    z_r <= z0;
                    i_r <= '0;
                end
                ST_ROTATE: begin
                    if (!z_r[23]) begin
                        x_r <= x_r - ys;
                        y_r <= y_r + xs;
                        z_r <= z_r - atan_i;
                    end else begin
                        x_r <= x_r + ys;
                        y_r <= y_r - xs;
                        z_r <= z_r + atan_i;
                    end
                    i_r <= i_r + 5'd1;
                end
                ST_FINISH: begin
                    crd_x    <= x_r;
                    crd_y    <= y_r;
                    crd_done <= 1'b1;
                    crd_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_rotate.sv
// Directed bench for cordic_rotate: polar vectors with hand-computed x/y.
// Ports: drives all DUT inputs, samples outputs on the falling edge.
module tb_cordic_rotate;

    localparam int ITER = 12;

    logic        clk;
    logic        rst_n;
    logic        crd_start;
    logic [23:0] crd_angle;
    logic [23:0] crd_magnitude;
    logic        crd_busy;
    logic        crd_done;
    logic [23:0] crd_x;
    logic [23:0] crd_y;

    int checks   = 0;
    int failures = 0;

    cordic_rotate #(.ITERATIONS(ITER)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .crd_start     (crd_start),
        .crd_angle     (crd_angle),
        .crd_magnitude (crd_magnitude),
        .crd_busy      (crd_busy),
        .crd_done      (crd_done),
        .crd_x         (crd_x),
        .crd_y         (crd_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs,
                         input int exp_v, input int tol);
        int d;
        checks++;
        d = obs - exp_v;
        if (d < 0) d = -d;
        if (d > tol) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d tol %0d",
                     tag, obs, exp_v, tol);
        end
    endtask

    function automatic int tol_of(input int mag);
        int m;
        m = (mag < 0) ? -mag : mag;
        return m * 2 / 1000 + 4;
    endfunction

    function automatic int sx(input logic [23:0] v);
        return int'($signed(v));
    endfunction

    // Issue one request and return at the falling edge where done shows.
    task automatic run(input int ang, input int mag,
                       output int lat, output int blow);
        crd_angle     = 24'(ang);
        crd_magnitude = 24'(mag);
        crd_start     = 1'b1;
        lat  = -1;
        blow = 0;
        @(posedge clk);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            crd_start     = 1'b0;
            crd_angle     = 24'd777;
            crd_magnitude = 24'd4321;
            if (crd_done) begin
                lat = k;
                break;
            end
            if (!crd_busy) blow++;
        end
    endtask

    task automatic vec(input string tag, input int ang, input int mag,
                       input int ex, input int ey);
        int lat, blow;
        run(ang, mag, lat, blow);
        check({tag, "_lat"}, lat, ITER + 2, 0);
        check({tag, "_x"}, sx(crd_x), ex, tol_of(mag));
        check({tag, "_y"}, sx(crd_y), ey, tol_of(mag));
    endtask

    initial begin
        int lat, blow, dn;
        rst_n         = 1'b0;
        crd_start     = 1'b0;
        crd_angle     = '0;
        crd_magnitude = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(crd_busy), 0, 0);
        check("rst_done", int'(crd_done), 0, 0);
        check("rst_x", sx(crd_x), 0, 0);
        check("rst_y", sx(crd_y), 0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run(0, 10000, lat, blow);
        check("a0_lat", lat, ITER + 2, 0);
        check("a0_busy", blow, 0, 0);
        check("a0_x", sx(crd_x), 10000, tol_of(10000));
        check("a0_y", sx(crd_y), 0, tol_of(10000));

        // Back-to-back: each request issued in the done cycle.
        vec("a45", 5895, 10000, 7071, 7071);
        vec("a90", 11790, 10000, 0, 10000);
        vec("am135", -17685, 20000, -14142, -14142);
        vec("a180", 23580, 10000, -10000, 0);
        vec("am180", -23580, 10000, -10000, 0);
        vec("aclamp", 30000, 10000, -10000, 0);

        run(0, 0, lat, blow);
        check("m0_lat", lat, 0, 0);
        check("m0_x", sx(crd_x), 0, 0);
        check("m0_y", sx(crd_y), 0, 0);

        vec("p34", 6960, 5000, 3000, 4000);
        vec("pq2", 16620, 10000, -6000, 8000);
        vec("pq4", -8827, 13000, 5000, -12000);
        vec("negm", 5895, -10000, -7071, -7071);

        // Start held high through the whole conversion.
        crd_angle     = 24'd0;
        crd_magnitude = 24'd10000;
        crd_start     = 1'b1;
        @(posedge clk);
        dn = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (crd_done) begin
                dn++;
                crd_start = 1'b0;
            end
        end
        crd_start = 1'b0;
        check("hold_dones", dn, 1, 0);
        check("hold_x", sx(crd_x), 10000, tol_of(10000));

        // Reset in the middle of ROTATE.
        crd_angle     = 24'd5895;
        crd_magnitude = 24'd10000;
        crd_start     = 1'b1;
        @(posedge clk);
        repeat (5) @(negedge clk);
        crd_start = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("mrst_busy", int'(crd_busy), 0, 0);
        check("mrst_done", int'(crd_done), 0, 0);
        check("mrst_x", sx(crd_x), 0, 0);
        check("mrst_y", sx(crd_y), 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (crd_done) dn++;
        end
        check("mrst_nodone", dn, 0, 0);

        vec("recov", 0, 8000, 8000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
